// File: rtl/demux_8ch_event_counter.sv
// Per-channel saturating event counters on the 1-to-8 demux output bus, with
// request/response readback, clear-on-read, clear-all and a sticky one-hot checker.
// Build option DEMUX_EVT_EDGE_MODE_EN: count rising edges of y_in instead of high cycles.
module demux_8ch_event_counter #(
    parameter int CNT_W = 16,
    parameter int CH_N  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CH_N-1:0]  y_in,
    input  logic             rd_req,
    input  logic [2:0]       rd_ch,
    input  logic             rd_clr,
    output logic             rd_valid,
    output logic [CNT_W-1:0] rd_data,
    output logic             rd_sat,
    input  logic             clr_all,
    output logic             onehot_err,
    output logic [CH_N-1:0]  err_ch
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q [CH_N];
    logic [CNT_W-1:0] cnt_d [CH_N];
    logic [CH_N-1:0]  sat_q, sat_d;
    logic [CH_N-1:0]  evt;
    logic             multi_hot;

    logic             err_q, err_d;
    logic [CH_N-1:0]  err_ch_q, err_ch_d;

    logic             rd_valid_q, rd_valid_d;
    logic [CNT_W-1:0] rd_data_q, rd_data_d;
    logic             rd_sat_q, rd_sat_d;

`ifdef DEMUX_EVT_EDGE_MODE_EN
    logic [CH_N-1:0]  y_prev_q, y_prev_d;

    // Clearing the history on clr_all makes a channel already high count as a fresh edge.
    assign y_prev_d = clr_all ? '0 : y_in;
    assign evt      = y_in & ~y_prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            y_prev_q <= '0;
        end else begin
            y_prev_q <= y_prev_d;
        end
    end
`else
    assign evt = y_in;
`endif

    // Clearing x & (x-1) drops the lowest set bit; anything left means two or more were set.
    assign multi_hot = |(y_in & (y_in - CH_N'(1)));

    // NOTE: every always_comb output gets its default first, so no path can infer a latch.
    always_comb begin
        for (int i = 0; i < CH_N; i++) begin
            cnt_d[i] = cnt_q[i];
            sat_d[i] = sat_q[i];
            // Clears outrank the increment, so an event on the clearing cycle is lost.
            if (clr_all || (rd_req && rd_clr && (rd_ch == 3'(i)))) begin
                cnt_d[i] = '0;
                sat_d[i] = 1'b0;
            end else if (evt[i] && (cnt_q[i] != CNT_MAX)) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
                sat_d[i] = (cnt_d[i] == CNT_MAX);
            end
        end
    end

    always_comb begin
        err_d    = err_q;
        err_ch_d = err_ch_q;
        if (clr_all) begin
            err_d    = 1'b0;
            err_ch_d = '0;
        end else if (multi_hot && !err_q) begin
            err_d    = 1'b1;
            err_ch_d = y_in;
        end
    end

    // The response is taken from current state, i.e. before this cycle's update or clear.
    always_comb begin
        rd_valid_d = rd_req;
        rd_data_d  = rd_data_q;
        rd_sat_d   = rd_sat_q;
        if (rd_req) begin
            rd_data_d = cnt_q[rd_ch];
            rd_sat_d  = sat_q[rd_ch];
        end
    end

    // NOTE: the counter array is architectural state, so every entry is reset, not just the control bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CH_N; i++) begin
                cnt_q[i] <= '0;
            end
            sat_q      <= '0;
            err_q      <= 1'b0;
            err_ch_q   <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_sat_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from the same pre-edge values.
            cnt_q      <= cnt_d;
            sat_q      <= sat_d;
            err_q      <= err_d;
            err_ch_q   <= err_ch_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_sat_q   <= rd_sat_d;
        end
    end

    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;
    assign rd_sat     = rd_sat_q;
    assign onehot_err = err_q;
    assign err_ch     = err_ch_q;

endmodule

// File: tb/tb_demux_8ch_event_counter.sv
// Bench for demux_8ch_event_counter: a 16-bit and a 4-bit instance share stimulus and are
// checked every cycle against an unbounded-count model, plus hand-computed read results.
module tb_demux_8ch_event_counter;

`ifdef DEMUX_EVT_EDGE_MODE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] y_in;
    logic       rd_req;
    logic [2:0] rd_ch;
    logic       rd_clr;
    logic       clr_all;

    logic        a_valid, a_sat, a_err;
    logic [15:0] a_data;
    logic [7:0]  a_err_ch;
    logic        b_valid, b_sat, b_err;
    logic [3:0]  b_data;
    logic [7:0]  b_err_ch;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    demux_8ch_event_counter #(.CNT_W(16), .CH_N(8)) u_w16 (
        .clk(clk), .rst(rst), .y_in(y_in),
        .rd_req(rd_req), .rd_ch(rd_ch), .rd_clr(rd_clr),
        .rd_valid(a_valid), .rd_data(a_data), .rd_sat(a_sat),
        .clr_all(clr_all), .onehot_err(a_err), .err_ch(a_err_ch)
    );

    demux_8ch_event_counter #(.CNT_W(4), .CH_N(8)) u_w4 (
        .clk(clk), .rst(rst), .y_in(y_in),
        .rd_req(rd_req), .rd_ch(rd_ch), .rd_clr(rd_clr),
        .rd_valid(b_valid), .rd_data(b_data), .rd_sat(b_sat),
        .clr_all(clr_all), .onehot_err(b_err), .err_ch(b_err_ch)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: unbounded event totals per channel; a saturating counter of width w reads min(total, 2^w-1).
    int         tot [8];
    int         m_rd_tot;
    logic [7:0] m_prev;
    logic       m_valid;
    logic       m_err;
    logic [7:0] m_err_ch;

    function automatic int lim(input int raw, input int w);
        int mx = (1 << w) - 1;
        return (raw >= mx) ? mx : raw;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            foreach (tot[i]) tot[i] = 0;
            m_rd_tot = 0;
            m_prev   = '0;
            m_valid  = 1'b0;
            m_err    = 1'b0;
            m_err_ch = '0;
        end else begin
            m_valid = rd_req;
            if (rd_req) m_rd_tot = tot[rd_ch];
            if ($countones(y_in) > 1 && !m_err) begin
                m_err    = 1'b1;
                m_err_ch = y_in;
            end
            for (int i = 0; i < 8; i++) begin
                if (y_in[i] && !(EDGE && m_prev[i])) tot[i]++;
            end
            if (rd_req && rd_clr) tot[rd_ch] = 0;
            m_prev = y_in;
            if (clr_all) begin
                foreach (tot[i]) tot[i] = 0;
                m_prev   = '0;
                m_err    = 1'b0;
                m_err_ch = '0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("w16_valid",  a_valid,  m_valid);
            check("w16_data",   a_data,   lim(m_rd_tot, 16));
            check("w16_sat",    a_sat,    m_rd_tot >= 65535);
            check("w16_err",    a_err,    m_err);
            check("w16_err_ch", a_err_ch, m_err_ch);
            check("w4_valid",   b_valid,  m_valid);
            check("w4_data",    b_data,   lim(m_rd_tot, 4));
            check("w4_sat",     b_sat,    m_rd_tot >= 15);
            check("w4_err",     b_err,    m_err);
            check("w4_err_ch",  b_err_ch, m_err_ch);
        end
    end

    // All stimulus tasks start and end on a falling edge.
    task automatic drive(input logic [7:0] y, input int n);
        y_in = y;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_clr_all();
        clr_all = 1'b1;
        @(negedge clk);
        clr_all = 1'b0;
    endtask

    task automatic rd_expect(input string name, input logic [2:0] ch, input logic clr,
                             input int exp16, input logic sat16, input int exp4, input logic sat4);
        rd_req = 1'b1;
        rd_ch  = ch;
        rd_clr = clr;
        @(negedge clk);
        rd_req = 1'b0;
        rd_clr = 1'b0;
        check({name, "_v16"}, a_valid, 1'b1);
        check({name, "_d16"}, a_data,  exp16);
        check({name, "_s16"}, a_sat,   sat16);
        check({name, "_v4"},  b_valid, 1'b1);
        check({name, "_d4"},  b_data,  exp4);
        check({name, "_s4"},  b_sat,   sat4);
    endtask

    initial begin
        rst = 1'b1; y_in = '0; rd_req = 1'b0; rd_ch = '0; rd_clr = 1'b0; clr_all = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_valid",  a_valid,  1'b0);
        check("rst_data",   a_data,   16'd0);
        check("rst_err",    a_err,    1'b0);
        check("rst_err_ch", a_err_ch, 8'd0);
        check("rst_data4",  b_data,   4'd0);
        rst = 1'b0;

        // Single channel held for 5 cycles; all other channels stay at zero.
        drive(8'h04, 5);
        y_in = '0;
        rd_expect("t1_ch2", 3'd2, 1'b0, EDGE ? 1 : 5, 1'b0, EDGE ? 1 : 5, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i != 2) rd_expect("t1_other", 3'(i), 1'b0, 0, 1'b0, 0, 1'b0);
        end

        // Walking one, three passes, then eight back-to-back reads.
        pulse_clr_all();
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 8; i++) drive(8'h01 << i, 1);
        end
        y_in = '0;
        for (int i = 0; i < 8; i++) rd_expect("t2_walk", 3'(i), 1'b0, 3, 1'b0, 3, 1'b0);
        @(negedge clk);
        check("t2_valid_drop", a_valid, 1'b0);

        // Twenty separate activations of ch7: the 4-bit instance saturates, the 16-bit one does not.
        pulse_clr_all();
        for (int k = 0; k < 20; k++) begin
            drive(8'h80, 1);
            drive(8'h00, 1);
        end
        rd_expect("t3_sat_clr", 3'd7, 1'b1, 20, 1'b0, 15, 1'b1);
        rd_expect("t3_after",   3'd7, 1'b0, 0,  1'b0, 0,  1'b0);

        // One-hot violations: first capture sticks, every high bit still counts.
        pulse_clr_all();
        check("t4_err_clear", a_err, 1'b0);
        drive(8'h81, 1);
        check("t4_err_set",  a_err,    1'b1);
        check("t4_err_ch",   a_err_ch, 8'h81);
        drive(8'h06, 1);
        y_in = '0;
        check("t4_err_hold", b_err,    1'b1);
        check("t4_ch_hold",  b_err_ch, 8'h81);
        rd_expect("t4_ch0", 3'd0, 1'b0, 1, 1'b0, 1, 1'b0);
        rd_expect("t4_ch7", 3'd7, 1'b0, 1, 1'b0, 1, 1'b0);
        rd_expect("t4_ch1", 3'd1, 1'b0, 1, 1'b0, 1, 1'b0);
        rd_expect("t4_ch2", 3'd2, 1'b0, 1, 1'b0, 1, 1'b0);
        rd_expect("t4_ch3", 3'd3, 1'b0, 0, 1'b0, 0, 1'b0);

        // Clear-on-read while the channel is active: clear wins over that cycle's event.
        pulse_clr_all();
        check("t5_err_cleared", a_err, 1'b0);
        drive(8'h10, 3);
        rd_expect("t5_pre_clr", 3'd4, 1'b1, EDGE ? 1 : 3, 1'b0, EDGE ? 1 : 3, 1'b0);
        drive(8'h10, 4);
        y_in = '0;
        rd_expect("t5_post_clr", 3'd4, 1'b0, EDGE ? 0 : 4, 1'b0, EDGE ? 0 : 4, 1'b0);

        // Reset with a read request in the same cycle drops the response.
        drive(8'h10, 2);
        rd_req = 1'b1;
        rd_ch  = 3'd4;
        rst    = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        rst    = 1'b0;
        y_in   = '0;
        check("t5_rst_no_valid16", a_valid, 1'b0);
        check("t5_rst_no_valid4",  b_valid, 1'b0);
        for (int i = 0; i < 8; i++) rd_expect("t5_rst_zero", 3'(i), 1'b0, 0, 1'b0, 0, 1'b0);

        // Edge versus level: 4 high, 2 low, 3 high.
        drive(8'h01, 4);
        drive(8'h00, 2);
        drive(8'h01, 3);
        y_in = '0;
        rd_expect("t6_mode", 3'd0, 1'b0, EDGE ? 2 : 7, 1'b0, EDGE ? 2 : 7, 1'b0);

        // clr_all together with a read: pre-clear value returned, then everything is zero.
        clr_all = 1'b1;
        rd_expect("t7_clrall_rd", 3'd0, 1'b0, EDGE ? 2 : 7, 1'b0, EDGE ? 2 : 7, 1'b0);
        clr_all = 1'b0;
        rd_expect("t7_after", 3'd0, 1'b0, 0, 1'b0, 0, 1'b0);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
